// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler sharing one bit-serial "sequence detector" among 2**IDW requesters.
// Define DET_MEALY_EN for a combinational (Mealy) detector: no DRAIN state, det_Z sampled in every shift cycle.
module seq_detect_scheduler #(
  parameter  int          IDW   = 1,
  parameter  int          WIDTH = 8,
  parameter  int          CNTW  = 4,
  localparam int unsigned NREQ  = 2**IDW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    det_rst_n,
  output logic                    det_I,
  input  logic                    det_Z,
  output logic                    done,
  output logic [CNTW-1:0]         hit_count,
  output logic [IDW-1:0]          resp_id
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

  state_t           state, next_state;
  logic [IDW-1:0]   ptr, sel, idx;
  logic             found;
  logic [WIDTH-1:0] sreg;
  logic [BW-1:0]    bit_cnt;
  logic             grant_edge, last_bit, sample;
  logic             det_rst_n_d, det_I_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  assign last_bit = (bit_cnt == BW'(WIDTH-1));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (|req) next_state = CLEAR;
      CLEAR: next_state = SHIFT;
`ifdef DET_MEALY_EN
      SHIFT: if (last_bit) next_state = DONE;
`else
      SHIFT: if (last_bit) next_state = DRAIN;
      DRAIN: next_state = DONE;
`endif
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Round-robin: first set request after ptr; the IDW-bit add wraps modulo NREQ.
  always_comb begin
    sel   = ptr;
    idx   = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      idx = ptr + IDW'(off);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    grant_edge  = (state == IDLE) && (|req);
    busy        = (state != IDLE);
    done        = (state == DONE);
    gnt         = (state == CLEAR) ? (NREQ'(1) << resp_id) : '0;
    det_rst_n_d = (next_state != CLEAR);
    det_I_d     = (next_state == SHIFT) ? sreg[WIDTH-1] : 1'b0;
`ifdef DET_MEALY_EN
    sample      = (state == SHIFT);
`else
    // Moore Z lags its bit by one cycle, so shift cycle 0 carries no result yet.
    sample      = ((state == SHIFT) && (bit_cnt != '0)) || (state == DRAIN);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= IDW'(NREQ-1);
      resp_id   <= '0;
      sreg      <= '0;
      bit_cnt   <= '0;
      hit_count <= '0;
      det_rst_n <= 1'b0;
      det_I     <= 1'b0;
    end else begin
      det_rst_n <= det_rst_n_d;
      det_I     <= det_I_d;
      if (grant_edge) begin
        ptr       <= sel;
        resp_id   <= sel;
        sreg      <= data[sel*WIDTH +: WIDTH];
        hit_count <= '0;
      end else if (next_state == SHIFT) begin
        sreg <= {sreg[WIDTH-2:0], 1'b0};
      end
      if (state == SHIFT) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      else                bit_cnt <= '0;
      if (sample && det_Z && (hit_count != '1))
        hit_count <= hit_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Randomized self-checking bench for seq_detect_scheduler with behavioural "101" detectors.
module tb_seq_detect_scheduler;
  localparam int NREQ = 2;
  localparam int W    = 8;
  localparam int CW   = 4;
  localparam int W2   = 16;
  localparam int CW2  = 2;
`ifdef DET_MEALY_EN
  localparam int DRAIN_CYC = 0;
`else
  localparam int DRAIN_CYC = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_a = '0;
  logic [NREQ*W-1:0]  data_a = '0;
  logic [NREQ-1:0]    gnt_a;
  logic               busy_a, drst_a, di_a, dz_a, done_a;
  logic [CW-1:0]      hit_a;
  logic [0:0]         id_a;

  logic [NREQ-1:0]    req_b = '0;
  logic [NREQ*W2-1:0] data_b = '0;
  logic [NREQ-1:0]    gnt_b;
  logic               busy_b, drst_b, di_b, dz_b, done_b;
  logic [CW2-1:0]     hit_b;
  logic [0:0]         id_b;

  seq_detect_scheduler #(.IDW(1), .WIDTH(W), .CNTW(CW)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .data(data_a), .gnt(gnt_a), .busy(busy_a),
    .det_rst_n(drst_a), .det_I(di_a), .det_Z(dz_a), .done(done_a),
    .hit_count(hit_a), .resp_id(id_a));

  seq_detect_scheduler #(.IDW(1), .WIDTH(W2), .CNTW(CW2)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .data(data_b), .gnt(gnt_b), .busy(busy_b),
    .det_rst_n(drst_b), .det_I(di_b), .det_Z(dz_b), .done(done_b),
    .hit_count(hit_b), .resp_id(id_b));

  // Behavioural "101" detectors with overlap: history of the last three bits.
  logic [2:0] hist_a, hist_b;
  always_ff @(posedge clk or negedge drst_a)
    if (!drst_a) hist_a <= '0; else hist_a <= {hist_a[1:0], di_a};
  always_ff @(posedge clk or negedge drst_b)
    if (!drst_b) hist_b <= '0; else hist_b <= {hist_b[1:0], di_b};
`ifdef DET_MEALY_EN
  assign dz_a = (hist_a[1:0] == 2'b10) && di_a;
  assign dz_b = (hist_b[1:0] == 2'b10) && di_b;
`else
  assign dz_a = (hist_a == 3'b101);
  assign dz_b = (hist_b == 3'b101);
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int              ptr_m = NREQ-1;
  logic [NREQ-1:0] pend = '0;
  logic [W-1:0]    words [NREQ];
  logic [31:0]     last_hits = 0, last_id = 0;

  function automatic int ref_hits(input logic [15:0] w, input int width, input int cmax);
    int c = 0;
    for (int k = 2; k < width; k++)
      if (w[width+1-k] && !w[width-k] && w[width-1-k]) c++;
    return (c > cmax) ? cmax : c;
  endfunction

  function automatic int pick(input logic [NREQ-1:0] p, input int ptr);
    for (int off = 1; off <= NREQ; off++)
      if (p[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
    return -1;
  endfunction

  task automatic drive_a();
    req_a  = pend;
    data_a = {words[1], words[0]};
  endtask

  // mode 0: drop req after grant; 1: hold req and data; 2: random re-request and new arrivals
  task automatic run_job(input int mode, output int id, output int hits);
    int           exp_id, exp_hits;
    logic [W-1:0] w;
    logic [NREQ-1:0] nb;
    logic         got;
    drive_a();
    exp_id   = pick(pend, ptr_m);
    w        = words[exp_id];
    exp_hits = ref_hits(16'(w), W, 2**CW-1);
    id = -1; hits = -1; got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (gnt_a != '0) got = 1'b1;
      else begin
        check("idle_busy", busy_a, 0);
        check("hold_hit", hit_a, last_hits);
        check("hold_id", id_a, last_id);
      end
    end
    if (!got) begin
      check("gnt_timeout", 0, 1);
      return;
    end
    check("gnt", gnt_a, 32'(1) << exp_id);
    check("clear_rst_n", drst_a, 0);
    check("busy", busy_a, 1);
    ptr_m = exp_id;
    if (mode == 0) pend[exp_id] = 1'b0;
    else if (mode == 2) begin
      pend[exp_id] = 1'($urandom_range(0, 1));
      words[exp_id] = W'($urandom);
      nb = NREQ'($urandom_range(0, 3)) & ~pend;
      for (int k = 0; k < NREQ; k++) if (nb[k]) words[k] = W'($urandom);
      pend |= nb;
    end
    drive_a();
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("det_I", di_a, w[W-1-i]);
      check("done_early", done_a, 0);
    end
    if (DRAIN_CYC != 0) begin
      @(negedge clk);
      check("drain_I", di_a, 0);
      check("done_early", done_a, 0);
    end
    @(negedge clk);
    check("done", done_a, 1);
    check("hit_count", hit_a, exp_hits);
    check("resp_id", id_a, exp_id);
    id = int'(id_a); hits = int'(hit_a);
    last_hits = exp_hits; last_id = exp_id;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int id, h, cnt, dn, mono_bad, prev;
    logic got;
    words[0] = '0; words[1] = '0;
    reset = 1'b0;
    #1;
    check("rst_gnt", gnt_a, 0);   check("rst_busy", busy_a, 0);
    check("rst_det_rst_n", drst_a, 0); check("rst_det_I", di_a, 0);
    check("rst_done", done_a, 0); check("rst_hit", hit_a, 0);
    check("rst_id", id_a, 0);
    #1 reset = 1'b1;

    // Single job, word 8'hAA -> three overlapping matches
    pend = 2'b01; words[0] = 8'hAA; words[1] = 8'h5A;
    run_job(0, id, h);
    check("t2_id", id, 0); check("t2_hits", h, 3);

    // Both requesters held: strict alternation from a fresh pointer
    @(negedge clk); reset = 1'b0; #1 reset = 1'b1;
    ptr_m = NREQ-1; last_hits = 0; last_id = 0;
    pend = 2'b11; words[0] = 8'hFF; words[1] = 8'hAA;
    run_job(1, id, h); check("t3a_id", id, 0); check("t3a_hits", h, 0);
    run_job(1, id, h); check("t3b_id", id, 1); check("t3b_hits", h, 3);
    run_job(1, id, h); check("t3c_id", id, 0); check("t3c_hits", h, 0);

    // Randomized traffic with re-requests and mid-job data changes
    for (int j = 0; j < 40; j++) begin
      if (pend == '0) begin
        pend = NREQ'($urandom_range(1, 3));
        for (int k = 0; k < NREQ; k++) if (pend[k]) words[k] = W'($urandom);
      end
      run_job(2, id, h);
    end

    // Reset in the middle of SHIFT drops the job
    pend = 2'b01; words[0] = W'($urandom); drive_a();
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (gnt_a != '0) got = 1'b1;
    end
    check("t5_gnt_seen", got, 1);
    pend = '0; drive_a();
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t5_busy", busy_a, 0); check("t5_det_rst_n", drst_a, 0);
    check("t5_det_I", di_a, 0);  check("t5_hit", hit_a, 0);
    check("t5_id", id_a, 0);     check("t5_gnt", gnt_a, 0);
    check("t5_done", done_a, 0);
    @(negedge clk); reset = 1'b1;
    ptr_m = NREQ-1; last_hits = 0; last_id = 0;
    dn = 0;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (done_a) dn++;
    end
    check("t5_no_done", dn, 0);
    pend = 2'b10; words[1] = W'($urandom);
    run_job(0, id, h);
    check("t5_regrant_id", id, 1);

    // Saturation on the 16-bit / 2-bit-counter instance
    req_b = 2'b01; data_b = {16'h1234, 16'hAAAA};
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (gnt_b != '0) got = 1'b1;
    end
    check("t4_gnt", gnt_b, 2'b01);
    req_b = '0;
    cnt = 0; mono_bad = 0; prev = 0; got = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      cnt++;
      if (int'(hit_b) < prev) mono_bad++;
      prev = int'(hit_b);
      if (done_b) got = 1'b1;
    end
    check("t4_done_seen", got, 1);
    check("t4_latency", cnt, W2 + DRAIN_CYC + 1);
    check("t4_hits", hit_b, ref_hits(16'hAAAA, W2, 2**CW2-1));
    check("t4_hits_sat", hit_b, 3);
    check("t4_no_wrap", mono_bad, 0);
    check("t4_id", id_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
